sobol_sc_mgen: RTL and testbench

//   Multi-channel Sobol stochastic-computing bitstream generator; parametrised successor to the single-channel SC generator.

---
 rtl/sobol_sc_mgen.sv | 122 ++++++++++++
 tb/tb_sobol_sc_mgen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sobol_sc_mgen.sv
// Multi-channel Sobol stochastic-computing bitstream generator.
// All channels share one Gray-code index; each channel compares its Sobol value with a latched operand.
module sobol_sc_mgen #(
   parameter int N     = 6,
   parameter int CH    = 2,
   parameter int SEQ_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_in,
   input  logic [CH*N-1:0]       num,
   input  logic [N:0]            len,
   input  logic [CH*N*N-1:0]     m,
   output logic                  busy,
   output logic                  bit_vld,
   output logic [CH-1:0]         bits,
   output logic                  en_out,
   output logic [CH*SEQ_W-1:0]   seq,
   output logic [CH*(N+1)-1:0]   ones
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [N:0] FULL_LEN = (N+1)'(1) << N;

   state_t               state, state_nx;
   logic [N-1:0]         idx;
   logic [N:0]           cnt;
   logic [N:0]           len_r;
   logic [N:0]           len_c;
   logic [CH*N-1:0]      num_r;
   logic [CH*N*N-1:0]    m_r;
   logic [N-1:0]         x    [CH];
   logic [N-1:0]         x_nx [CH];
   logic [N-1:0]         dir  [CH][N];
   logic [N-1:0]         lz;
   logic [CH-1:0]        hit;

   assign len_c = (len > FULL_LEN) ? FULL_LEN : len;
   assign busy  = (state != S_IDLE);

   // One-hot of the lowest zero bit of idx; all-zero when idx is all ones.
   assign lz = ~idx & (idx + 1'b1);

   always_comb begin
      for (int unsigned c = 0; c < CH; c++) begin
         for (int unsigned k = 0; k < N; k++) begin
            dir[c][k] = m_r[(c*N+k)*N +: N] << (N-1-k);
         end
      end
   end

   always_comb begin
      for (int unsigned c = 0; c < CH; c++) begin
         x_nx[c] = x[c];
         for (int unsigned k = 0; k < N; k++) begin
            if (lz[k]) x_nx[c] = x[c] ^ dir[c][k];
         end
         if (&idx) x_nx[c] = '0;
         hit[c] = (x[c] < num_r[c*N +: N]);
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (en_in) state_nx = (len == '0) ? S_DONE : S_RUN;
         S_RUN:  if (cnt == len_r - 1'b1) state_nx = S_DONE;
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         idx     <= '0;
         cnt     <= '0;
         len_r   <= '0;
         num_r   <= '0;
         m_r     <= '0;
         bit_vld <= 1'b0;
         bits    <= '0;
         en_out  <= 1'b0;
         seq     <= '0;
         ones    <= '0;
         for (int unsigned c = 0; c < CH; c++) x[c] <= '0;
      end else begin
         state   <= state_nx;
         bit_vld <= 1'b0;
         en_out  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (en_in) begin
                  num_r <= num;
                  len_r <= len_c;
                  m_r   <= m;
                  idx   <= '0;
                  cnt   <= '0;
                  seq   <= '0;
                  ones  <= '0;
                  for (int unsigned c = 0; c < CH; c++) x[c] <= '0;
               end
            end
            S_RUN: begin
               bit_vld <= 1'b1;
               bits    <= hit;
               idx     <= idx + 1'b1;
               cnt     <= cnt + 1'b1;
               for (int unsigned c = 0; c < CH; c++) begin
                  x[c] <= x_nx[c];
                  seq[c*SEQ_W +: SEQ_W]  <= {seq[c*SEQ_W +: SEQ_W-1], hit[c]};
                  ones[c*(N+1) +: N+1]   <= ones[c*(N+1) +: N+1] + (N+1)'(hit[c]);
               end
            end
            S_DONE: en_out <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sobol_sc_mgen.sv
// Bench for sobol_sc_mgen: reference Sobol values built directly from the Gray code of the index.
module tb_sobol_sc_mgen;

   localparam int N     = 6;
   localparam int CH    = 2;
   localparam int SEQ_W = 32;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  en_in;
   logic [CH*N-1:0]       num;
   logic [N:0]            len;
   logic [CH*N*N-1:0]     m;
   logic                  busy;
   logic                  bit_vld;
   logic [CH-1:0]         bits;
   logic                  en_out;
   logic [CH*SEQ_W-1:0]   seq;
   logic [CH*(N+1)-1:0]   ones;

   int checks = 0;
   int errors = 0;

   logic [CH*N-1:0]       lat_num;
   logic [CH*N*N-1:0]     lat_m;
   int                    lat_len;
   logic [SEQ_W-1:0]      exp_seq  [CH];
   int                    exp_ones [CH];

   sobol_sc_mgen #(.N(N), .CH(CH), .SEQ_W(SEQ_W)) dut (
      .clk(clk), .rst(rst), .en_in(en_in), .num(num), .len(len), .m(m),
      .busy(busy), .bit_vld(bit_vld), .bits(bits), .en_out(en_out),
      .seq(seq), .ones(ones)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // x_i = XOR of v_k over set bits of gray(i mod 2^N), v_k = m_k << (N-1-k)
   function automatic logic [N-1:0] sob(input int c, input int i, input logic [CH*N*N-1:0] mm);
      int           ii;
      logic [N-1:0] g, x, v;
      ii = i % (1 << N);
      g  = N'(ii ^ (ii >> 1));
      x  = '0;
      for (int k = 0; k < N; k++) begin
         if (g[k]) begin
            v = mm[(c*N+k)*N +: N];
            x = x ^ (v << (N-1-k));
         end
      end
      return x;
   endfunction

   function automatic logic [CH*N*N-1:0] rand_m();
      logic [CH*N*N-1:0] mv;
      mv = '0;
      for (int c = 0; c < CH; c++)
         for (int k = 0; k < N; k++)
            mv[(c*N+k)*N +: N] = N'($urandom_range(0, (1 << k) - 1) * 2 + 1);
      return mv;
   endfunction

   task automatic start(input logic [CH*N-1:0] nv, input int lv,
                        input logic [CH*N*N-1:0] mv, input bit hold);
      @(negedge clk);
      num     = nv;
      len     = (N+1)'(lv);
      m       = mv;
      en_in   = 1'b1;
      lat_num = nv;
      lat_m   = mv;
      lat_len = (lv > (1 << N)) ? (1 << N) : lv;
      @(negedge clk);
      if (!hold) begin
         en_in = 1'b0;
         num   = CH*N'($urandom);
         len   = (N+1)'($urandom);
         m     = {$urandom, $urandom, $urandom};
      end
      check("start_vld", bit_vld, 0);
      check("start_busy", busy, 1);
   endtask

   task automatic collect(input int pulse_at);
      int   nb;
      bit   seen;
      logic b;
      nb   = 0;
      seen = 1'b0;
      for (int c = 0; c < CH; c++) begin
         exp_seq[c]  = '0;
         exp_ones[c] = 0;
      end
      for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
         if (pulse_at >= 0 && cyc == pulse_at) en_in = 1'b1;
         else if (pulse_at >= 0 && cyc == pulse_at + 1) en_in = 1'b0;
         @(negedge clk);
         if (bit_vld) begin
            if (nb < lat_len) begin
               for (int c = 0; c < CH; c++) begin
                  b = (sob(c, nb, lat_m) < lat_num[c*N +: N]);
                  check($sformatf("bit_c%0d_i%0d", c, nb), bits[c], b);
                  exp_seq[c]  = {exp_seq[c][SEQ_W-2:0], b};
                  exp_ones[c] = exp_ones[c] + int'(b);
               end
            end
            nb++;
         end
         if (en_out) begin
            seen = 1'b1;
            check("en_out_cycle", cyc, lat_len);
         end
      end
      check("en_out_seen", seen, 1);
      check("vld_count", nb, lat_len);
      for (int c = 0; c < CH; c++) begin
         check($sformatf("ones_c%0d", c), ones[c*(N+1) +: N+1], exp_ones[c]);
         check($sformatf("seq_c%0d", c), seq[c*SEQ_W +: SEQ_W], exp_seq[c]);
      end
   endtask

   task automatic post();
      @(negedge clk);
      check("post_en_out", en_out, 0);
      check("post_busy", busy, 0);
      check("post_vld", bit_vld, 0);
      for (int c = 0; c < CH; c++) begin
         check($sformatf("hold_ones_c%0d", c), ones[c*(N+1) +: N+1], exp_ones[c]);
         check($sformatf("hold_seq_c%0d", c), seq[c*SEQ_W +: SEQ_W], exp_seq[c]);
      end
   endtask

   initial begin
      logic [CH*N*N-1:0] mv;
      logic [CH*N-1:0]   nv;
      int                nbits;
      int                run1_ones [CH];
      bit                eo_seen;

      rst   = 1'b1;
      en_in = 1'b0;
      num   = '0;
      len   = '0;
      m     = '0;
      repeat (3) @(negedge clk);
      check("rst_outputs", {busy, bit_vld, bits, en_out, seq, ones}, 0);
      rst = 1'b0;

      // 1: ch0 all m_k=1, num=32, len=4 -> x 0,32,48,16
      mv = rand_m();
      for (int k = 0; k < N; k++) mv[k*N +: N] = N'(1);
      nv = {N'($urandom), N'(32)};
      start(nv, 4, mv, 1'b0);
      collect(-1);
      check("t1_seq", seq[3:0], 4'b1001);
      check("t1_ones", ones[N:0], 2);
      post();

      // 2: ch1 m=1,3,5,7,9,11, num=51, full period
      for (int k = 0; k < N; k++) mv[(N+k)*N +: N] = N'(2*k + 1);
      nv = {N'(51), N'($urandom)};
      start(nv, 64, mv, 1'b0);
      collect(-1);
      check("t2_ones", ones[2*(N+1)-1 -: N+1], 51);
      post();

      // 3: edge operands and zero length
      start({N'(0), N'(0)}, 64, rand_m(), 1'b0);
      collect(-1);
      check("t3_seq0", seq, 0);
      post();
      start({N'(63), N'(63)}, 64, rand_m(), 1'b0);
      collect(-1);
      check("t3_ones63", ones[N:0], 63);
      post();
      start({N'(40), N'(17)}, 0, rand_m(), 1'b0);
      collect(-1);
      check("t3_len0_ones", ones, 0);
      post();

      // 4: clamped length, en_in pulse during RUN is ignored
      start({N'($urandom), N'($urandom)}, 100, rand_m(), 1'b0);
      collect(5);
      post();
      eo_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (en_out || busy) eo_seen = 1'b1;
      end
      check("t4_no_restart", eo_seen, 0);

      // 5: reset at bit 10 aborts with no en_out
      mv = rand_m();
      nv = {N'($urandom), N'($urandom)};
      start(nv, 64, mv, 1'b0);
      nbits = 0;
      for (int cyc = 0; cyc < 100 && nbits < 10; cyc++) begin
         @(negedge clk);
         if (bit_vld) nbits++;
      end
      check("t5_reach10", nbits, 10);
      #1 rst = 1'b1;
      #1 check("t5_rst_outputs", {busy, bit_vld, bits, en_out, seq, ones}, 0);
      @(negedge clk);
      rst = 1'b0;
      eo_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (en_out) eo_seen = 1'b1;
      end
      check("t5_no_en_out", eo_seen, 0);
      start(nv, 64, mv, 1'b0);
      collect(-1);
      post();

      // 6: back-to-back with en_in held
      mv = rand_m();
      nv = {N'($urandom), N'($urandom)};
      start(nv, 20, mv, 1'b1);
      collect(-1);
      for (int c = 0; c < CH; c++) run1_ones[c] = exp_ones[c];
      @(negedge clk);
      en_in = 1'b0;
      check("t6_restart_busy", busy, 1);
      check("t6_restart_vld", bit_vld, 0);
      collect(-1);
      for (int c = 0; c < CH; c++)
         check($sformatf("t6_ones_c%0d", c), ones[c*(N+1) +: N+1], run1_ones[c]);
      post();

      // random runs
      for (int r = 0; r < 8; r++) begin
         start({N'($urandom), N'($urandom)}, $urandom_range(0, 100), rand_m(), 1'b0);
         collect(-1);
         post();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
